// File: rtl/board_write_arbiter_if.sv
// Request bus for the board write arbiter: two tile-write requesters.
// master = requester side, slave = arbiter side.
interface board_write_arbiter_if #(
  parameter int TILE_W = 5
);
  logic              req0_valid;
  logic [5:0]        req0_col;
  logic [4:0]        req0_row;
  logic [TILE_W-1:0] req0_tile;
  logic              req0_ready;

  logic              req1_valid;
  logic [5:0]        req1_col;
  logic [4:0]        req1_row;
  logic [TILE_W-1:0] req1_tile;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_col, req0_row, req0_tile,
    output req1_valid, req1_col, req1_row, req1_tile,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_col, req0_row, req0_tile,
    input  req1_valid, req1_col, req1_row, req1_tile,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/board_write_arbiter.sv
// board_write_arbiter: owns the board tile RAM write port. Round-robin between
// game logic (req0) and the secondary updater (req1), plus a full-board clear
// sequencer. (col,row) -> row*BOARD_COLS+col, same mapping as the renderer.
// Optional build macro VBLANK_ONLY_EN: grants and clear steps only while vblank=1.
module board_write_arbiter #(
  parameter int BOARD_COLS = 40,
  parameter int BOARD_ROWS = 30,
  parameter int ADDR_W     = 11,
  parameter int TILE_W     = 5
) (
  input  logic              clock,
  input  logic              reset,
  board_write_arbiter_if.slave req,
  input  logic              clear_start,
  input  logic [TILE_W-1:0] clear_tile,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              vblank,
  output logic [ADDR_W-1:0] wraddress,
  output logic [TILE_W-1:0] data,
  output logic              wren,
  output logic              drop
);

  localparam int                CELLS = BOARD_COLS * BOARD_ROWS;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [TILE_W-1:0] fill_tile;
  logic              rr_last1;   // 1: req1 won the last grant, so req0 wins the next conflict
  logic              last_step;  // last fill write issued; done/busy update one cycle later

`ifdef VBLANK_ONLY_EN
  logic vb_ok;
  assign vb_ok = vblank;
`else
  logic vb_ok;
  logic unused_vblank;
  assign vb_ok         = 1'b1;
  assign unused_vblank = vblank;
`endif

  // Both requesters packed side by side so the address/range logic is generated once per lane.
  logic [1:0]             req_valid;
  logic [1:0][5:0]        req_col;
  logic [1:0][4:0]        req_row;
  logic [1:0][TILE_W-1:0] req_tile;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0]             req_oor;

  assign req_valid = {req.req1_valid, req.req0_valid};
  assign req_col   = {req.req1_col,   req.req0_col};
  assign req_row   = {req.req1_row,   req.req0_row};
  assign req_tile  = {req.req1_tile,  req.req0_tile};

  for (genvar g = 0; g < 2; g++) begin : g_req
    // Full-width linear address, truncated to the RAM width.
    assign req_addr[g] = ADDR_W'(32'(req_row[g]) * 32'(BOARD_COLS) + 32'(req_col[g]));
    assign req_oor[g]  = (32'(req_col[g]) >= 32'(BOARD_COLS)) ||
                         (32'(req_row[g]) >= 32'(BOARD_ROWS));
  end

  logic [1:0] gnt;
  logic       sel;

  // Grant: only in IDLE, never in reset, and a same-cycle clear_start outranks requests.
  always_comb begin
    gnt = 2'b00;
    if (!reset && state == IDLE && !clear_start && vb_ok) begin
      if (req_valid[0] && req_valid[1]) gnt = rr_last1 ? 2'b01 : 2'b10;
      else                              gnt = req_valid;
    end
  end

  assign sel            = gnt[1];
  assign req.req0_ready = gnt[0];
  assign req.req1_ready = gnt[1];

  // FSM, round-robin pointer, clear counter and the registered RAM write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      fill_tile  <= '0;
      rr_last1   <= 1'b1;
      last_step  <= 1'b0;
      wren       <= 1'b0;
      wraddress  <= '0;
      data       <= '0;
      drop       <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      wren       <= 1'b0;
      drop       <= 1'b0;
      last_step  <= 1'b0;
      clear_done <= last_step;
      if (last_step) clear_busy <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            fill_tile  <= clear_tile;
            cnt        <= '0;
            clear_busy <= 1'b1;
          end else if (|gnt) begin
            rr_last1 <= sel;
            if (req_oor[sel]) begin
              drop <= 1'b1;
            end else begin
              wren      <= 1'b1;
              wraddress <= req_addr[sel];
              data      <= req_tile[sel];
            end
          end
        end
        CLEAR: begin
          // Counter holds while vb_ok is low so the fill resumes where it paused.
          if (vb_ok) begin
            wren      <= 1'b1;
            wraddress <= cnt;
            data      <= fill_tile;
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= IDLE;
              last_step <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_write_arbiter.sv
// Scoreboard bench for board_write_arbiter: a reference model predicts readys and
// pushes expected RAM writes; an independent monitor pops and compares them.
module tb_board_write_arbiter;
  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 11;
  localparam int TILE_W = 5;
  localparam int CELLS  = COLS * ROWS;
`ifdef VBLANK_ONLY_EN
  localparam bit VB_EN = 1'b1;
`else
  localparam bit VB_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear_start = 1'b0;
  logic [TILE_W-1:0] clear_tile = '0;
  logic              clear_busy, clear_done;
  logic              vblank = 1'b1;
  logic [ADDR_W-1:0] wraddress;
  logic [TILE_W-1:0] data;
  logic              wren, drop;

  board_write_arbiter_if #(.TILE_W(TILE_W)) bus();

  board_write_arbiter #(.BOARD_COLS(COLS), .BOARD_ROWS(ROWS), .ADDR_W(ADDR_W), .TILE_W(TILE_W)) dut (
    .clock(clock), .reset(reset), .req(bus),
    .clear_start(clear_start), .clear_tile(clear_tile),
    .clear_busy(clear_busy), .clear_done(clear_done), .vblank(vblank),
    .wraddress(wraddress), .data(data), .wren(wren), .drop(drop)
  );

  always #5 clock = ~clock;

  typedef struct { bit is_drop; int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic wr_t mk(input int col, input int row, input int tile);
    wr_t w;
    w.is_drop = (col >= COLS) || (row >= ROWS);
    w.addr    = (row * COLS + col) % (1 << ADDR_W);
    w.data    = tile;
    return w;
  endfunction

  // Reference model: evaluated after the inputs and comb readys have settled.
  int blocked;  // remaining clear writes; arbiter is closed while nonzero
  bit last1;    // requester 1 won last
  initial begin
    bit vb, e0, e1, v0, v1;
    blocked = 0;
    last1   = 1'b1;
    forever begin
      @(negedge clock); #1;
      e0 = 1'b0; e1 = 1'b0;
      vb = VB_EN ? vblank : 1'b1;
      if (reset) begin
        exp_q.delete();
        blocked = 0;
        last1   = 1'b1;
      end else if (blocked > 0) begin
        if (vb) blocked--;
      end else if (clear_start) begin
        blocked = CELLS;
        for (int a = 0; a < CELLS; a++) exp_q.push_back('{1'b0, a, int'(clear_tile)});
      end else if (vb) begin
        v0 = bus.req0_valid; v1 = bus.req1_valid;
        if (v0 && v1) begin e0 = last1; e1 = !last1; end
        else begin e0 = v0; e1 = v1; end
      end
      chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
      if (e0) begin last1 = 1'b0; exp_q.push_back(mk(bus.req0_col, bus.req0_row, bus.req0_tile)); end
      if (e1) begin last1 = 1'b1; exp_q.push_back(mk(bus.req1_col, bus.req1_row, bus.req1_tile)); end
    end
  end

  // Monitor: every wren or drop cycle consumes one expected entry.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (wren === 1'b1 || drop === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {wren, drop}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_kind", {wren, drop}, e.is_drop ? 32'd1 : 32'd2);
          if (!e.is_drop) begin
            chk("wraddress", 32'(wraddress), 32'(e.addr));
            chk("data", 32'(data), 32'(e.data));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic set_req(input int which, input bit v, input int col, input int row, input int tile);
    if (which == 0) begin
      bus.req0_valid = v; bus.req0_col = 6'(col); bus.req0_row = 5'(row); bus.req0_tile = TILE_W'(tile);
    end else begin
      bus.req1_valid = v; bus.req1_col = 6'(col); bus.req1_row = 5'(row); bus.req1_tile = TILE_W'(tile);
    end
  endtask

  initial begin
    int n_busy, n_bw, n_done, n_wr;
    bit g, granted, found, a0, a1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_wren", 32'(wren), 0);
    chk("rst_wraddress", 32'(wraddress), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_done", 32'(clear_done), 0);
    chk("rst_drop", 32'(drop), 0);

    // single write (3,2,7) -> address 83, then wren low again
    tick();
    set_req(0, 1, 3, 2, 7);
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clock);
    chk("t1_wren", 32'(wren), 1);
    @(negedge clock);
    chk("t1_wren_off", 32'(wren), 0);

    // conflict after reset: req0 first, then alternate
    tick();
    do_reset(2);
    set_req(0, 1, 0, 0, 1);
    set_req(1, 1, 39, 29, 2);
    repeat (4) tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (2) tick();

    // out-of-range column -> accepted, dropped
    set_req(1, 1, 40, 0, 3);
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clock);
    chk("t3_drop", 32'(drop), 1);
    chk("t3_wren", 32'(wren), 0);
    tick();

    // clear beats a pending request, then the request is granted
    vblank = 1'b1;
    set_req(0, 1, 1, 1, 9);
    clear_start = 1'b1; clear_tile = 5'd5;
    tick();
    clear_start = 1'b0;
    n_busy = 0; n_bw = 0; n_done = 0; granted = 0;
    for (int i = 0; i < 1215; i++) begin
      @(negedge clock);
      if (clear_busy) n_busy++;
      if (clear_busy && wren) n_bw++;
      if (clear_done) n_done++;
      g = bus.req0_valid && bus.req0_ready;
      @(posedge clock); #1;
      if (!VB_EN) vblank = 1'($urandom_range(0, 1));
      if (g) begin bus.req0_valid = 1'b0; granted = 1'b1; end
    end
    vblank = 1'b1;
    chk("t4_busy_cycles", n_busy, CELLS + 1);
    chk("t4_fill_writes", n_bw, CELLS);
    chk("t4_done_pulses", n_done, 1);
    chk("t4_req0_granted", 32'(granted), 1);

    // reset in the middle of a fill
    clear_start = 1'b1; clear_tile = 5'd12;
    tick();
    clear_start = 1'b0;
    found = 0;
    for (int i = 0; i < 1300 && !found; i++) begin
      @(negedge clock);
      if (wren && wraddress == 11'd600) begin found = 1; reset = 1'b1; end
    end
    chk("t5_reached_600", 32'(found), 1);
    if (!found) reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t5_wren_after_rst", 32'(wren), 0);
    chk("t5_busy_after_rst", 32'(clear_busy), 0);
    n_done = 0;
    repeat (3) begin @(negedge clock); if (clear_done) n_done++; end
    chk("t5_no_done", n_done, 0);
    tick();
    clear_start = 1'b1; clear_tile = 5'd3;
    tick();
    clear_start = 1'b0;
    found = 0;
    for (int i = 0; i < 1300 && !found; i++) begin
      @(negedge clock);
      if (clear_done) found = 1;
    end
    chk("t5_refill_done", 32'(found), 1);
    tick();

`ifdef VBLANK_ONLY_EN
    // outside vblank nothing is granted
    vblank = 1'b0;
    set_req(0, 1, 2, 2, 4);
    repeat (3) tick();
    vblank = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    repeat (2) tick();
    // clear accepted outside vblank; pause with the counter at 100
    vblank = 1'b0;
    clear_start = 1'b1; clear_tile = 5'd6;
    tick();
    clear_start = 1'b0;
    vblank = 1'b1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clock);
      if (wren && wraddress == 11'd99) begin found = 1; vblank = 1'b0; end
    end
    chk("vb_reached_99", 32'(found), 1);
    n_wr = 0; n_busy = 0;
    repeat (10) begin
      @(negedge clock);
      if (wren) n_wr++;
      if (clear_busy) n_busy++;
    end
    chk("vb_paused_writes", n_wr, 0);
    chk("vb_paused_busy", n_busy, 10);
    vblank = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (wren) begin found = 1; chk("vb_resume_addr", 32'(wraddress), 100); end
    end
    chk("vb_resumed", 32'(found), 1);
    found = 0;
    for (int i = 0; i < 1300 && !found; i++) begin
      @(negedge clock);
      if (clear_done) found = 1;
    end
    chk("vb_fill_done", 32'(found), 1);
    tick();
`endif

    // randomized traffic, requests held stable until accepted
    a0 = 0; a1 = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clock); #1;
      if (!bus.req0_valid || a0)
        set_req(0, $urandom_range(0, 2) != 0, $urandom_range(0, 45), $urandom_range(0, 31), $urandom_range(0, 31));
      if (!bus.req1_valid || a1)
        set_req(1, $urandom_range(0, 2) != 0, $urandom_range(0, 45), $urandom_range(0, 31), $urandom_range(0, 31));
      vblank = VB_EN ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
    end
    vblank = 1'b1;
    for (int i = 0; i < 20 && (bus.req0_valid || bus.req1_valid); i++) begin
      @(negedge clock);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clock); #1;
      if (a0) bus.req0_valid = 1'b0;
      if (a1) bus.req1_valid = 1'b0;
    end
    chk("drain_valids", {bus.req0_valid, bus.req1_valid}, 0);
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
